// File: rtl/tx_fcs_gen.sv
// tx_fcs_gen -- appends an IEEE 802.3 CRC-32 FCS to outbound frames.
//
// Frames arrive one byte per transfer (destination address first, no FCS).
// Each byte is forwarded through a single output register stage. After the
// byte flagged by in_last, the four FCS bytes follow, and out_last marks the
// fourth one. With TX_FCS_GEN_PAD_EN defined, frames shorter than MIN_LEN
// bytes are first extended with 0x00 pad bytes, which are also covered by the
// FCS. With the macro undefined there is no pad stage and MIN_LEN is unused.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   reset_n    asynchronous active-low reset
//   in_valid   upstream byte present
//   in_data    frame byte
//   in_last    final payload byte of the frame
//   in_ready   block accepts in_data this cycle
//   out_valid  out_data holds a byte for the MAC transmitter
//   out_data   payload, pad or FCS byte
//   out_last   fourth FCS byte
//   out_ready  downstream accepts out_data this cycle
module tx_fcs_gen #(
    parameter int MIN_LEN = 60
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    input  logic       in_last,
    output logic       in_ready,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       out_last,
    input  logic       out_ready
);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PAD, S_FCS} state_t;

    localparam logic [31:0] POLY = 32'h04C11DB7;

    state_t      state_q, state_d;
    logic [31:0] crc_q, crc_d;
    logic [10:0] cnt_q, cnt_d;
    logic [1:0]  fcs_cnt_q, fcs_cnt_d;
    logic        out_valid_q, out_valid_d;
    logic [7:0]  out_data_q, out_data_d;
    logic        out_last_q, out_last_d;
    logic        alive_q;

    logic        out_room;
    logic        in_fire;
    logic [10:0] cnt_inc;

`ifdef TX_FCS_GEN_PAD_EN
    localparam logic [10:0] MIN_LEN_C = 11'(MIN_LEN);
`else
    logic unused_min_len;
    assign unused_min_len = ^32'(MIN_LEN);
`endif

    // Non-reflected register, bit 0 of the byte shifted in first.
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[31] ^ d[i]) r = {r[30:0], 1'b0} ^ POLY;
            else              r = {r[30:0], 1'b0};
        end
        return r;
    endfunction

    function automatic logic [7:0] rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
        return r;
    endfunction

    // Byte k carries crc[31-8k:24-8k], complemented and bit-reversed so the
    // MAC's LSB-first serialisation sends x^31 first.
    function automatic logic [7:0] fcs_byte(input logic [31:0] c, input logic [1:0] k);
        logic [7:0] s;
        case (k)
            2'd0:    s = c[31:24];
            2'd1:    s = c[23:16];
            2'd2:    s = c[15:8];
            default: s = c[7:0];
        endcase
        return rev8(~s);
    endfunction

    assign out_room = ~out_valid_q | out_ready;
    // The extra out_last term keeps a new frame from being accepted in the
    // same cycle the previous frame's final FCS byte leaves.
    assign in_ready = alive_q & ((state_q == S_IDLE) | (state_q == S_DATA)) & out_room
                      & ~(out_valid_q & out_last_q);
    assign in_fire  = in_valid & in_ready;
    assign cnt_inc  = (cnt_q == 11'h7FF) ? cnt_q : cnt_q + 11'd1;

    always_comb begin
        state_d     = state_q;
        crc_d       = crc_q;
        cnt_d       = cnt_q;
        fcs_cnt_d   = fcs_cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end

        case (state_q)
            S_IDLE, S_DATA: begin
                if (in_fire) begin
                    out_valid_d = 1'b1;
                    out_data_d  = in_data;
                    out_last_d  = 1'b0;
                    crc_d       = crc_byte(crc_q, in_data);
                    cnt_d       = cnt_inc;
                    if (in_last) begin
`ifdef TX_FCS_GEN_PAD_EN
                        state_d = (cnt_inc < MIN_LEN_C) ? S_PAD : S_FCS;
`else
                        state_d = S_FCS;
`endif
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
`ifdef TX_FCS_GEN_PAD_EN
            S_PAD: begin
                if (out_room) begin
                    out_valid_d = 1'b1;
                    out_data_d  = 8'h00;
                    crc_d       = crc_byte(crc_q, 8'h00);
                    cnt_d       = cnt_inc;
                    if (cnt_inc >= MIN_LEN_C) state_d = S_FCS;
                end
            end
`endif
            S_FCS: begin
                if (out_room) begin
                    out_valid_d = 1'b1;
                    out_data_d  = fcs_byte(crc_q, fcs_cnt_q);
                    out_last_d  = (fcs_cnt_q == 2'd3);
                    fcs_cnt_d   = fcs_cnt_q + 2'd1;
                    if (fcs_cnt_q == 2'd3) begin
                        state_d = S_IDLE;
                        crc_d   = 32'hFFFFFFFF;
                        cnt_d   = 11'd0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            crc_q       <= 32'hFFFFFFFF;
            cnt_q       <= 11'd0;
            fcs_cnt_q   <= 2'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
            out_last_q  <= 1'b0;
            alive_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            crc_q       <= crc_d;
            cnt_q       <= cnt_d;
            fcs_cnt_q   <= fcs_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            alive_q     <= 1'b1;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;

endmodule
